// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Definitions shared by the FIR MAC scheduler and its tap store:
//   state_t          - sequencer states (IDLE, ISSUE, DRAIN, DONE)
//   OP_ADD / OP_MUL  - op_sel encodings understood by the shared ALU
//   ALU_LATENCY      - cycles from operands driven to result valid
//   DEFAULT_DW/AW    - default operand and accumulator widths
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;

    localparam int ALU_LATENCY = 2;

    localparam int DEFAULT_DW = 16;
    localparam int DEFAULT_AW = 32;

endpackage

// File: rtl/fir_tap_store.sv
// -----------------------------------------------------------------------------
// fir_tap_store
// Coefficient bank and sample delay line for the FIR MAC scheduler.
//   clk, rst        clock, asynchronous active-high reset (clears everything)
//   i_coef_we       coefficient write strobe (already qualified by caller)
//   i_coef_addr     coefficient index to write
//   i_coef_data     signed coefficient value
//   i_shift         shift i_sample into x[0], x[i] <= x[i-1]
//   i_sample        signed sample to shift in
//   i_clear         zero the delay line (wins over i_shift)
//   i_coef_idx      read index for the coefficient port
//   o_coef          coef[i_coef_idx] (0 if out of range)
//   i_x_idx         read index for the delay-line port
//   o_x             x[i_x_idx] (0 if out of range)
// -----------------------------------------------------------------------------
module fir_tap_store #(
    parameter int TAPS = 4,
    parameter int DW   = 16,
    parameter int IW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_coef_we,
    input  logic [IW-1:0]        i_coef_addr,
    input  logic signed [DW-1:0] i_coef_data,
    input  logic                 i_shift,
    input  logic signed [DW-1:0] i_sample,
    input  logic                 i_clear,
    input  logic [IW-1:0]        i_coef_idx,
    output logic signed [DW-1:0] o_coef,
    input  logic [IW-1:0]        i_x_idx,
    output logic signed [DW-1:0] o_x
);

    logic signed [DW-1:0] r_coef [TAPS];
    logic signed [DW-1:0] r_x    [TAPS];

    logic w_wr_ok;
    logic w_coef_rd_ok;
    logic w_x_rd_ok;

    // Index range guards are only needed when TAPS does not fill the index
    // space; for power-of-two tap counts every index is legal.
    generate
        if (TAPS == (1 << IW)) begin : g_full_range
            assign w_wr_ok      = 1'b1;
            assign w_coef_rd_ok = 1'b1;
            assign w_x_rd_ok    = 1'b1;
        end else begin : g_partial_range
            assign w_wr_ok      = ({1'b0, i_coef_addr} < (IW+1)'(TAPS));
            assign w_coef_rd_ok = ({1'b0, i_coef_idx}  < (IW+1)'(TAPS));
            assign w_x_rd_ok    = ({1'b0, i_x_idx}     < (IW+1)'(TAPS));
        end
    endgenerate

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others (the delay-line shift
    // below depends on this).
    // NOTE: the coefficient bank is a small register array, not a RAM macro, so
    // it can be (and must be) cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
        end else if (i_coef_we && w_wr_ok) begin
            r_coef[i_coef_addr] <= i_coef_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
        end else if (i_shift) begin
            r_x[0] <= i_sample;
            for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
        end
    end

    assign o_coef = w_coef_rd_ok ? r_coef[i_coef_idx] : '0;
    assign o_x    = w_x_rd_ok    ? r_x[i_x_idx]       : '0;

endmodule

// File: rtl/fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// fir_mac_scheduler
// Computes one FIR output per accepted sample by streaming TAPS multiplies
// through a shared two-stage signed ALU and accumulating the products.
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input sample handshake (ready only in IDLE, not on clear)
//   in_sample         signed input sample
//   coef_we/addr/data coefficient write port (honoured in IDLE or DONE)
//   clear             zero the delay line (honoured in IDLE; blocks accept)
//   alu_op_sel        OP_MUL while sequencing, OP_ADD otherwise
//   alu_a, alu_b      ALU operands: coefficient and delayed sample
//   alu_result        ALU result, valid ALU_LATENCY cycles after operands
//   out_valid/ready   output handshake; out_data held stable in DONE
//   out_data          signed filter output (wraps modulo 2^AW)
//   busy              high whenever not IDLE
// -----------------------------------------------------------------------------
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int TAPS = 4,
    parameter int DW   = DEFAULT_DW,
    parameter int AW   = DEFAULT_AW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DW-1:0]         in_sample,
    input  logic                         coef_we,
    input  logic [$clog2(TAPS)-1:0]      coef_addr,
    input  logic signed [DW-1:0]         coef_data,
    input  logic                         clear,
    output logic [1:0]                   alu_op_sel,
    output logic signed [DW-1:0]         alu_a,
    output logic signed [DW-1:0]         alu_b,
    input  logic signed [AW-1:0]         alu_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [AW-1:0]         out_data,
    output logic                         busy
);

    localparam int            IW       = $clog2(TAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [IW-1:0]            r_idx;
    // Bit 0 marks a product entering the ALU; the MSB marks the product that
    // is on alu_result this cycle.
    logic [ALU_LATENCY-1:0]   r_vpipe;
    logic signed [AW-1:0]     r_acc;

    logic                     w_accept;
    logic                     w_issue;
    logic                     w_coef_we;
    logic                     w_clear;
    logic signed [DW-1:0]     w_coef;
    logic signed [DW-1:0]     w_x;

    assign w_accept  = in_valid && in_ready;
    assign w_issue   = (r_state == ISSUE);
    assign w_coef_we = coef_we && ((r_state == IDLE) || (r_state == DONE));
    assign w_clear   = clear && (r_state == IDLE);

    fir_tap_store #(
        .TAPS (TAPS),
        .DW   (DW),
        .IW   (IW)
    ) u_tap_store (
        .clk         (clk),
        .rst         (rst),
        .i_coef_we   (w_coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .i_shift     (w_accept),
        .i_sample    (in_sample),
        .i_clear     (w_clear),
        .i_coef_idx  (r_idx),
        .o_coef      (w_coef),
        .i_x_idx     (r_idx),
        .o_x         (w_x)
    );

    // NOTE: every output and the next state get a default before the case, so
    // no path through this block leaves a variable unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        out_valid    = 1'b0;
        out_data     = '0;
        alu_op_sel   = OP_ADD;
        alu_a        = '0;
        alu_b        = '0;

        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                // clear has priority: the sample is refused in that cycle.
                in_ready = !clear;
                if (in_valid && !clear) w_state_next = ISSUE;
            end
            ISSUE: begin
                alu_op_sel = OP_MUL;
                alu_a      = w_coef;
                alu_b      = w_x;
                if (r_idx == LAST_IDX) w_state_next = DRAIN;
            end
            DRAIN: begin
                // The ALU samples op_sel in its second stage, so MUL must stay
                // asserted while the last products are still in flight.
                alu_op_sel = OP_MUL;
                if (r_vpipe[ALU_LATENCY-2:0] == '0) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_vpipe <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_next;
            r_vpipe <= {r_vpipe[ALU_LATENCY-2:0], w_issue};

            if (w_accept) begin
                r_idx <= '0;
            end else if (w_issue) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end

            // Accept only happens in IDLE, where the valid pipe is empty, so
            // clearing and accumulating never collide.
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_vpipe[ALU_LATENCY-1]) begin
                r_acc <= r_acc + alu_result;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_scheduler
// Self-checking bench for fir_mac_scheduler. Provides a two-stage signed ALU
// (op_sel sampled at stage two, shares rst), a behavioural FIR model and a
// scoreboard queue of expected outputs.
// -----------------------------------------------------------------------------
module tb_fir_mac_scheduler;

    localparam int TAPS = 4;
    localparam int DW   = 16;
    localparam int AW   = 32;
    localparam int IW   = $clog2(TAPS);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_sample;
    logic                 coef_we;
    logic [IW-1:0]        coef_addr;
    logic signed [DW-1:0] coef_data;
    logic                 clear;
    logic [1:0]           alu_op_sel;
    logic signed [DW-1:0] alu_a;
    logic signed [DW-1:0] alu_b;
    logic signed [AW-1:0] alu_result;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_data;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    logic signed [AW-1:0] exp_q[$];
    logic signed [DW-1:0] m_coef [TAPS];
    logic signed [DW-1:0] m_x    [TAPS];

    always #5 clk = ~clk;

    fir_mac_scheduler #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .clear      (clear),
        .alu_op_sel (alu_op_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    // Two-stage ALU: operands registered in stage one, op applied in stage two.
    logic signed [DW-1:0] alu_a1, alu_b1;
    logic signed [AW-1:0] alu_prod, alu_sum;
    assign alu_prod = alu_a1 * alu_b1;
    assign alu_sum  = alu_a1 + alu_b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a1     <= '0;
            alu_b1     <= '0;
            alu_result <= '0;
        end else begin
            alu_a1     <= alu_a;
            alu_b1     <= alu_b;
            alu_result <= (alu_op_sel == 2'b01) ? alu_prod : alu_sum;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic logic signed [AW-1:0] model_out();
        logic signed [AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < TAPS; i++) acc = acc + m_coef[i] * m_x[i];
        return acc;
    endfunction

    task automatic model_shift(input logic signed [DW-1:0] s);
        for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = s;
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = '0;
            m_x[i]    = '0;
        end
    endtask

    // ---------------- stimulus helpers (start and end at a negedge) --------
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic signed [DW-1:0] val);
        coef_we   = 1'b1;
        coef_addr = IW'(addr);
        coef_data = val;
        @(negedge clk);
        coef_we   = 1'b0;
        m_coef[addr] = val;
    endtask

    task automatic do_clear();
        in_valid  = 1'b1;
        in_sample = 16'sd5;
        clear     = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_blocks_ready: got %b, expected 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_no_accept: busy got %b, expected 0", busy);
        end
        for (int i = 0; i < TAPS; i++) m_x[i] = '0;
    endtask

    // Offers one sample, scores its output, optionally holds DONE for `hold`
    // cycles, optionally attempts a coefficient write while busy.
    task automatic run_sample(input logic signed [DW-1:0] s, input int hold,
                              input bit busy_write);
        int                   lat;
        logic signed [AW-1:0] exp_v;
        logic signed [AW-1:0] held;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL in_ready_idle: got %b, expected 1", in_ready);
        end
        in_valid  = 1'b1;
        in_sample = s;
        model_shift(s);
        exp_q.push_back(model_out());
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        checks++;
        if ({alu_op_sel, alu_a, alu_b} !== {2'b01, m_coef[0], m_x[0]}) begin
            failures++;
            $display("FAIL first_issue: got op=%b a=%0d b=%0d, expected op=01 a=%0d b=%0d",
                     alu_op_sel, alu_a, alu_b, m_coef[0], m_x[0]);
        end
        if (busy_write) begin
            coef_we   = 1'b1;
            coef_addr = '0;
            coef_data = 16'sd100;
        end
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        checks++;
        if (lat != TAPS + 3) begin
            failures++;
            $display("FAIL out_latency: got %0d cycles, expected %0d", lat, TAPS + 3);
        end
        if (exp_q.size() == 0) begin
            exp_v = 'x;
        end else begin
            exp_v = exp_q.pop_front();
        end
        checks++;
        if (out_data !== exp_v) begin
            failures++;
            $display("FAIL out_data: got %0d, expected %0d", out_data, exp_v);
        end
        held = exp_v;
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            in_sample = 16'sh1234;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b101 || out_data !== held) begin
                failures++;
                $display("FAIL backpressure_hold: got v/r/b=%b%b%b data=%0d, expected 101 data=%0d",
                         out_valid, in_ready, busy, out_data, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL release_to_idle: got r/v/b=%b%b%b, expected 100",
                     in_ready, out_valid, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, out_valid, busy, alu_op_sel} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got r/v/b/op=%b, expected 10000",
                     {in_ready, out_valid, busy, alu_op_sel});
        end
        checks++;
        if (out_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
            failures++;
            $display("FAIL reset_data: got out=%0d a=%0d b=%0d, expected 0 0 0",
                     out_data, alu_a, alu_b);
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < TAPS; i++) write_coef(i, DW'(i + 1));
        run_sample(16'sd1, 0, 1'b0);
        for (int i = 0; i < TAPS; i++) run_sample(16'sd0, 0, 1'b0);
    endtask

    task automatic test_signed();
        do_clear();
        write_coef(0, -16'sd3);
        write_coef(1, 16'sd5);
        write_coef(2, 16'sd0);
        write_coef(3, 16'sd0);
        run_sample(16'sd7, 0, 1'b0);
        run_sample(-16'sd2, 0, 1'b0);
    endtask

    task automatic test_wrap();
        do_clear();
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'sh8000);
        for (int i = 0; i < 4; i++) run_sample(16'sh8000, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_sample(16'sd3, 10, 1'b0);
    endtask

    task automatic test_coef_write_busy();
        do_clear();
        write_coef(0, 16'sd2);
        write_coef(1, -16'sd1);
        write_coef(2, 16'sd3);
        write_coef(3, 16'sd7);
        run_sample(16'sd9, 0, 1'b1);
        run_sample(16'sd4, 0, 1'b0);
        write_coef(0, 16'sd100);
        run_sample(16'sd1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_issue();
        in_valid  = 1'b1;
        in_sample = 16'sd50;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, busy, alu_op_sel} !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_ctrl: got r/v/b/op=%b, expected 10000",
                     {in_ready, out_valid, busy, alu_op_sel});
        end
        checks++;
        if (out_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
            failures++;
            $display("FAIL midreset_data: got out=%0d a=%0d b=%0d, expected 0 0 0",
                     out_data, alu_a, alu_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < TAPS; i++) write_coef(i, DW'(i + 1));
        run_sample(16'sd1, 0, 1'b0);
        run_sample(16'sd0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < TAPS; i++) write_coef(i, DW'($urandom));
        for (int n = 0; n < 6; n++) run_sample(DW'($urandom), 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_signed();
        test_wrap();
        test_backpressure();
        test_coef_write_busy();
        test_reset_mid_issue();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
